// File: rtl/obi_arb_pkg.sv
// Shared types and limits for the OBI round-robin arbiter.
// No logic; types only.
// No flow control of its own.
package obi_arb_pkg;

    // Arbiter phase: free, holding a request until grant, or waiting for the response.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOCK = 2'b01,
        RESP = 2'b10
    } arb_state_e;

    // Largest supported manager count.
    localparam int MAX_MGR = 8;

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-set search over a request vector, starting at the round-robin pointer.
// Latency: purely combinational.
// Backpressure: none; the result simply follows the inputs.
module rr_pick #(
    parameter int NUM_MGR   = 2,
    parameter int IDX_WIDTH = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1
) (
    input  logic [NUM_MGR-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic [IDX_WIDTH-1:0] winner_o,
    output logic                 valid_o
);

    logic [IDX_WIDTH:0]   sum;
    logic [IDX_WIDTH-1:0] idx;

    // Walk offsets from farthest to nearest so the request closest to the pointer wins last.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int off = NUM_MGR - 1; off >= 0; off--) begin
            sum = {1'b0, ptr_i} + (IDX_WIDTH + 1)'(off);
            if (sum >= (IDX_WIDTH + 1)'(NUM_MGR)) begin
                sum = sum - (IDX_WIDTH + 1)'(NUM_MGR);
            end
            idx = sum[IDX_WIDTH-1:0];
            if (req_i[idx]) begin
                winner_o = idx;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate among NUM_MGR managers, one transaction in flight.
// Latency: grant in the request cycle when the subordinate grants combinationally; next grant one cycle after response completion.
// Backpressure: a pending request is frozen until granted; the response is held until the owning manager's rready.
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int NUM_MGR    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    input  logic [NUM_MGR-1:0]               mgr_req_i,
    output logic [NUM_MGR-1:0]               mgr_gnt_o,
    input  logic [NUM_MGR*ADDR_WIDTH-1:0]    mgr_addr_i,
    input  logic [NUM_MGR-1:0]               mgr_we_i,
    input  logic [NUM_MGR*DATA_WIDTH/8-1:0]  mgr_be_i,
    input  logic [NUM_MGR*DATA_WIDTH-1:0]    mgr_wdata_i,
    output logic [NUM_MGR-1:0]               mgr_rvalid_o,
    input  logic [NUM_MGR-1:0]               mgr_rready_i,
    output logic [DATA_WIDTH-1:0]            mgr_rdata_o,
    output logic                             mgr_err_o,
    output logic                             sbr_req_o,
    input  logic                             sbr_gnt_i,
    output logic [ADDR_WIDTH-1:0]            sbr_addr_o,
    output logic                             sbr_we_o,
    output logic [DATA_WIDTH/8-1:0]          sbr_be_o,
    output logic [DATA_WIDTH-1:0]            sbr_wdata_o,
    input  logic                             sbr_rvalid_i,
    output logic                             sbr_rready_o,
    input  logic [DATA_WIDTH-1:0]            sbr_rdata_i,
    input  logic                             sbr_err_i
);

    localparam int IDX_WIDTH = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1;
    localparam int BE_WIDTH  = DATA_WIDTH / 8;

    arb_state_e           state_q, state_d;
    logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH-1:0] owner_q, owner_d;
    logic [IDX_WIDTH-1:0] winner;
    logic                 any_req;
    logic [NUM_MGR-1:0]   pick_req;

    logic                 fwd;
    logic [IDX_WIDTH-1:0] sel;
    logic [NUM_MGR-1:0]   gnt_vec;
    logic [NUM_MGR-1:0]   rvalid_vec;
    logic                 resp_phase;
    logic                 rready;

    // Only a free arbiter searches; while locked or responding the winner is fixed.
    assign pick_req = (state_q == IDLE) ? mgr_req_i : '0;

    rr_pick #(
        .NUM_MGR   (NUM_MGR),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_pick (
        .req_i    (pick_req),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner),
        .valid_o  (any_req)
    );

    // Phase sequencing, grant pass-through and response routing.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        fwd        = 1'b0;
        sel        = owner_q;
        gnt_vec    = '0;
        rvalid_vec = '0;
        resp_phase = 1'b0;
        rready     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    fwd     = 1'b1;
                    sel     = winner;
                    owner_d = winner;
                    if (sbr_gnt_i) begin
                        gnt_vec[winner] = 1'b1;
                        state_d         = RESP;
                    end else begin
                        state_d = LOCK;
                    end
                end
            end
            LOCK: begin
                // A manager withdrawing an ungranted request gets no grant; start over.
                if (mgr_req_i[owner_q]) begin
                    fwd = 1'b1;
                    if (sbr_gnt_i) begin
                        gnt_vec[owner_q] = 1'b1;
                        state_d          = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                resp_phase          = 1'b1;
                rvalid_vec[owner_q] = sbr_rvalid_i;
                rready              = mgr_rready_i[owner_q];
                if (sbr_rvalid_i && mgr_rready_i[owner_q]) begin
                    rr_ptr_d = (owner_q == IDX_WIDTH'(NUM_MGR - 1)) ? '0 : owner_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are forced low while reset is held so nothing leaks out mid-reset.
    assign sbr_req_o    = reset_ni & fwd;
    assign sbr_addr_o   = (reset_ni && fwd) ? mgr_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign sbr_we_o     = reset_ni & fwd & mgr_we_i[sel];
    assign sbr_be_o     = (reset_ni && fwd) ? mgr_be_i[sel*BE_WIDTH +: BE_WIDTH] : '0;
    assign sbr_wdata_o  = (reset_ni && fwd) ? mgr_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign mgr_gnt_o    = reset_ni ? gnt_vec : '0;
    assign mgr_rvalid_o = reset_ni ? rvalid_vec : '0;
    assign mgr_rdata_o  = (reset_ni && resp_phase) ? sbr_rdata_i : '0;
    assign mgr_err_o    = reset_ni & resp_phase & sbr_err_i;
    assign sbr_rready_o = reset_ni & rready;

    // Phase, owner and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
module tb_obi_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk_i = 1'b0;
    logic            reset_ni;
    logic [N-1:0]    mgr_req_i, mgr_gnt_o, mgr_we_i, mgr_rvalid_o, mgr_rready_i;
    logic [N*AW-1:0] mgr_addr_i;
    logic [N*4-1:0]  mgr_be_i;
    logic [N*DW-1:0] mgr_wdata_i;
    logic [DW-1:0]   mgr_rdata_o, sbr_rdata_i, sbr_wdata_o;
    logic            mgr_err_o, sbr_req_o, sbr_gnt_i, sbr_we_o, sbr_rvalid_i, sbr_rready_o, sbr_err_i;
    logic [AW-1:0]   sbr_addr_o;
    logic [3:0]      sbr_be_o;

    int n_vec = 0;
    int n_err = 0;

    obi_rr_arbiter #(.NUM_MGR(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .mgr_req_i(mgr_req_i), .mgr_gnt_o(mgr_gnt_o), .mgr_addr_i(mgr_addr_i),
        .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
        .mgr_rvalid_o(mgr_rvalid_o), .mgr_rready_i(mgr_rready_i),
        .mgr_rdata_o(mgr_rdata_o), .mgr_err_o(mgr_err_o),
        .sbr_req_o(sbr_req_o), .sbr_gnt_i(sbr_gnt_i), .sbr_addr_o(sbr_addr_o),
        .sbr_we_o(sbr_we_o), .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o),
        .sbr_rvalid_i(sbr_rvalid_i), .sbr_rready_o(sbr_rready_o),
        .sbr_rdata_i(sbr_rdata_i), .sbr_err_i(sbr_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0, a1;
        logic [1:0]  we;
        logic        gnt, rv;
        logic [1:0]  rr;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  x_gnt;
        logic        x_sreq;
        logic [31:0] x_addr;
        logic        x_we;
        logic [3:0]  x_be;
        logic [31:0] x_wd;
        logic [1:0]  x_rv;
        logic [31:0] x_rd;
        logic        x_err;
        logic        x_srr;
    } vec_t;

    vec_t vq[$];

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {20'd0, mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o, sbr_req_o,
                sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o, sbr_rready_o};
    endfunction

    task automatic add(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] we, input logic gnt, input logic rv, input logic [1:0] rr,
                       input logic [31:0] rdata, input logic err,
                       input logic [1:0] xg, input logic xsreq, input logic [31:0] xaddr,
                       input logic xwe, input logic [3:0] xbe, input logic [31:0] xwd,
                       input logic [1:0] xrv, input logic [31:0] xrd, input logic xerr, input logic xsrr);
        vec_t v;
        v.req = req; v.a0 = a0; v.a1 = a1; v.we = we; v.gnt = gnt; v.rv = rv; v.rr = rr;
        v.rdata = rdata; v.err = err; v.x_gnt = xg; v.x_sreq = xsreq; v.x_addr = xaddr;
        v.x_we = xwe; v.x_be = xbe; v.x_wd = xwd; v.x_rv = xrv; v.x_rd = xrd;
        v.x_err = xerr; v.x_srr = xsrr;
        vq.push_back(v);
    endtask

    task automatic clear_inputs();
        mgr_req_i = '0; mgr_we_i = '0; mgr_rready_i = '0; mgr_addr_i = '0;
        sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b0; sbr_rdata_i = '0; sbr_err_i = 1'b0;
        mgr_be_i = {4'b0011, 4'b1111};
        mgr_wdata_i = {32'h0000_1234, 32'hAAAA_5555};
    endtask

    // Reference model state: 0 = free, 1 = request waiting for grant, 2 = waiting for response.
    int m_phase, m_owner, m_ptr;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    initial begin
        logic [1:0]  e_gnt, e_rv;
        logic        e_sreq, e_we, e_err, e_srr;
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0]  e_be;
        int          sel, np, no, nptr, w;

        clear_inputs();
        reset_ni = 1'b0;

        // Directed table: single read, contention, delayed grant, backpressure, write+err, withdrawal.
        //   req   a0       a1       we  g  rv rr   rdata         e  | xg  sq xaddr    xwe xbe   xwd            xrv  xrd           xe xsrr
        add(2'b01, 32'h10,  32'h0,   0, 1, 0, 3, 32'h0,        0,  2'b01, 1, 32'h10,  0, 4'hF, 32'hAAAA5555, 2'b00, 32'h0,        0, 0);
        add(2'b00, 32'h0,   32'h0,   0, 0, 1, 3, 32'hDEADBEEF, 0,  2'b00, 0, 32'h0,   0, 4'h0, 32'h0,        2'b01, 32'hDEADBEEF, 0, 1);
        add(2'b11, 32'h100, 32'h200, 0, 1, 0, 3, 32'h0,        0,  2'b10, 1, 32'h200, 0, 4'h3, 32'h1234,     2'b00, 32'h0,        0, 0);
        add(2'b11, 32'h100, 32'h200, 0, 1, 1, 3, 32'h1,        0,  2'b00, 0, 32'h0,   0, 4'h0, 32'h0,        2'b10, 32'h1,        0, 1);
        add(2'b11, 32'h100, 32'h200, 0, 1, 0, 3, 32'h0,        0,  2'b01, 1, 32'h100, 0, 4'hF, 32'hAAAA5555, 2'b00, 32'h0,        0, 0);
        add(2'b11, 32'h100, 32'h200, 0, 1, 1, 3, 32'h2,        0,  2'b00, 0, 32'h0,   0, 4'h0, 32'h0,        2'b01, 32'h2,        0, 1);
        add(2'b11, 32'h100, 32'h200, 0, 1, 0, 3, 32'h0,        0,  2'b10, 1, 32'h200, 0, 4'h3, 32'h1234,     2'b00, 32'h0,        0, 0);
        add(2'b11, 32'h100, 32'h200, 0, 1, 1, 3, 32'h6,        0,  2'b00, 0, 32'h0,   0, 4'h0, 32'h0,        2'b10, 32'h6,        0, 1);
        add(2'b11, 32'h100, 32'h200, 0, 1, 0, 3, 32'h0,        0,  2'b01, 1, 32'h100, 0, 4'hF, 32'hAAAA5555, 2'b00, 32'h0,        0, 0);
        add(2'b11, 32'h100, 32'h200, 0, 1, 1, 3, 32'h8,        0,  2'b00, 0, 32'h0,   0, 4'h0, 32'h0,        2'b01, 32'h8,        0, 1);
        add(2'b01, 32'h20,  32'h300, 0, 0, 0, 3, 32'h0,        0,  2'b00, 1, 32'h20,  0, 4'hF, 32'hAAAA5555, 2'b00, 32'h0,        0, 0);
        add(2'b11, 32'h20,  32'h300, 0, 0, 0, 3, 32'h0,        0,  2'b00, 1, 32'h20,  0, 4'hF, 32'hAAAA5555, 2'b00, 32'h0,        0, 0);
        add(2'b11, 32'h20,  32'h300, 0, 0, 0, 3, 32'h0,        0,  2'b00, 1, 32'h20,  0, 4'hF, 32'hAAAA5555, 2'b00, 32'h0,        0, 0);
        add(2'b11, 32'h20,  32'h300, 0, 1, 0, 3, 32'h0,        0,  2'b01, 1, 32'h20,  0, 4'hF, 32'hAAAA5555, 2'b00, 32'h0,        0, 0);
        add(2'b10, 32'h20,  32'h300, 0, 0, 1, 3, 32'h3,        0,  2'b00, 0, 32'h0,   0, 4'h0, 32'h0,        2'b01, 32'h3,        0, 1);
        add(2'b10, 32'h20,  32'h300, 0, 1, 0, 3, 32'h0,        0,  2'b10, 1, 32'h300, 0, 4'h3, 32'h1234,     2'b00, 32'h0,        0, 0);
        add(2'b10, 32'h20,  32'h300, 0, 0, 1, 1, 32'h4,        0,  2'b00, 0, 32'h0,   0, 4'h0, 32'h0,        2'b10, 32'h4,        0, 0);
        add(2'b10, 32'h20,  32'h300, 0, 0, 1, 1, 32'h4,        0,  2'b00, 0, 32'h0,   0, 4'h0, 32'h0,        2'b10, 32'h4,        0, 0);
        add(2'b00, 32'h20,  32'h300, 0, 0, 1, 2, 32'h4,        0,  2'b00, 0, 32'h0,   0, 4'h0, 32'h0,        2'b10, 32'h4,        0, 1);
        add(2'b10, 32'h0,   32'h300, 2, 1, 0, 3, 32'h0,        0,  2'b10, 1, 32'h300, 1, 4'h3, 32'h1234,     2'b00, 32'h0,        0, 0);
        add(2'b00, 32'h0,   32'h300, 0, 0, 1, 3, 32'h0,        1,  2'b00, 0, 32'h0,   0, 4'h0, 32'h0,        2'b10, 32'h0,        1, 1);
        add(2'b01, 32'h40,  32'h300, 0, 0, 0, 3, 32'h0,        0,  2'b00, 1, 32'h40,  0, 4'hF, 32'hAAAA5555, 2'b00, 32'h0,        0, 0);
        add(2'b00, 32'h40,  32'h300, 0, 1, 0, 3, 32'h0,        0,  2'b00, 0, 32'h0,   0, 4'h0, 32'h0,        2'b00, 32'h0,        0, 0);
        add(2'b10, 32'h40,  32'h300, 0, 1, 0, 3, 32'h0,        0,  2'b10, 1, 32'h300, 0, 4'h3, 32'h1234,     2'b00, 32'h0,        0, 0);
        add(2'b00, 32'h40,  32'h300, 0, 0, 1, 2, 32'h5,        0,  2'b00, 0, 32'h0,   0, 4'h0, 32'h0,        2'b10, 32'h5,        0, 1);

        // Reset state: every output low even with all inputs active.
        mgr_req_i = 2'b11; sbr_gnt_i = 1'b1; sbr_rvalid_i = 1'b1; mgr_rready_i = 2'b11;
        #2;
        cmp("reset outputs", all_outs(), '0);
        @(negedge clk_i);
        clear_inputs();
        reset_ni = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk_i);
            mgr_req_i = vq[i].req; mgr_addr_i = {vq[i].a1, vq[i].a0}; mgr_we_i = vq[i].we;
            sbr_gnt_i = vq[i].gnt; sbr_rvalid_i = vq[i].rv; mgr_rready_i = vq[i].rr;
            sbr_rdata_i = vq[i].rdata; sbr_err_i = vq[i].err;
            #1;
            cmp($sformatf("v%0d gnt", i),    128'(mgr_gnt_o),    128'(vq[i].x_gnt));
            cmp($sformatf("v%0d sreq", i),   128'(sbr_req_o),    128'(vq[i].x_sreq));
            cmp($sformatf("v%0d addr", i),   128'(sbr_addr_o),   128'(vq[i].x_addr));
            cmp($sformatf("v%0d we", i),     128'(sbr_we_o),     128'(vq[i].x_we));
            cmp($sformatf("v%0d be", i),     128'(sbr_be_o),     128'(vq[i].x_be));
            cmp($sformatf("v%0d wdata", i),  128'(sbr_wdata_o),  128'(vq[i].x_wd));
            cmp($sformatf("v%0d rvalid", i), 128'(mgr_rvalid_o), 128'(vq[i].x_rv));
            cmp($sformatf("v%0d rdata", i),  128'(mgr_rdata_o),  128'(vq[i].x_rd));
            cmp($sformatf("v%0d err", i),    128'(mgr_err_o),    128'(vq[i].x_err));
            cmp($sformatf("v%0d rready", i), 128'(sbr_rready_o), 128'(vq[i].x_srr));
        end

        // Reset during a response: pointer is advanced to 1 first, so a surviving pointer would pick mgr1.
        @(negedge clk_i);
        clear_inputs(); mgr_addr_i = {32'h600, 32'h50};
        mgr_req_i = 2'b01; sbr_gnt_i = 1'b1;
        #1; cmp("rst seq grant0", 128'(mgr_gnt_o), 128'(2'b01));
        @(negedge clk_i);
        mgr_req_i = 2'b00; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b1; mgr_rready_i = 2'b11;
        #1; cmp("rst seq resp0", 128'(mgr_rvalid_o), 128'(2'b01));
        @(negedge clk_i);
        mgr_req_i = 2'b01; sbr_gnt_i = 1'b1; sbr_rvalid_i = 1'b0;
        #1; cmp("rst seq grant1", 128'(mgr_gnt_o), 128'(2'b01));
        @(negedge clk_i);
        mgr_req_i = 2'b11; sbr_rvalid_i = 1'b1; mgr_rready_i = 2'b00; sbr_rdata_i = 32'h77;
        #1; cmp("rst seq in resp", 128'(mgr_rvalid_o), 128'(2'b01));
        reset_ni = 1'b0;
        #1; cmp("rst async outputs", all_outs(), '0);
        @(negedge clk_i);
        cmp("rst held outputs", all_outs(), '0);
        reset_ni = 1'b1; sbr_rvalid_i = 1'b0; mgr_rready_i = 2'b11;
        #1;
        cmp("rst first gnt", 128'(mgr_gnt_o), 128'(2'b01));
        cmp("rst first addr", 128'(sbr_addr_o), 128'(32'h50));
        @(negedge clk_i);
        mgr_req_i = 2'b00; sbr_rvalid_i = 1'b1;
        #1; cmp("rst seq final resp", 128'(mgr_rvalid_o), 128'(2'b01));

        // Randomized run against the transaction-level model, starting from a fresh reset.
        @(negedge clk_i);
        clear_inputs();
        reset_ni = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        m_phase = 0; m_owner = 0; m_ptr = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_i);
            mgr_req_i    = 2'($urandom_range(0, 3));
            mgr_addr_i   = {$urandom, $urandom};
            mgr_we_i     = 2'($urandom_range(0, 3));
            mgr_be_i     = 8'($urandom);
            mgr_wdata_i  = {$urandom, $urandom};
            sbr_gnt_i    = 1'($urandom_range(0, 1));
            sbr_rvalid_i = 1'($urandom_range(0, 1));
            mgr_rready_i = 2'($urandom_range(0, 3));
            sbr_rdata_i  = $urandom;
            sbr_err_i    = 1'($urandom_range(0, 1));
            #1;
            e_gnt = '0; e_rv = '0; e_sreq = 0; e_we = 0; e_err = 0; e_srr = 0;
            e_addr = '0; e_wd = '0; e_rd = '0; e_be = '0;
            sel = -1; np = m_phase; no = m_owner; nptr = m_ptr;
            if (m_phase == 0) begin
                w = pick(mgr_req_i, m_ptr);
                if (w >= 0) begin
                    sel = w; no = w;
                    if (sbr_gnt_i) begin e_gnt[w] = 1'b1; np = 2; end
                    else np = 1;
                end
            end else if (m_phase == 1) begin
                if (mgr_req_i[m_owner]) begin
                    sel = m_owner;
                    if (sbr_gnt_i) begin e_gnt[m_owner] = 1'b1; np = 2; end
                end else begin
                    np = 0;
                end
            end else begin
                e_rv[m_owner] = sbr_rvalid_i;
                e_rd = sbr_rdata_i; e_err = sbr_err_i; e_srr = mgr_rready_i[m_owner];
                if (sbr_rvalid_i && mgr_rready_i[m_owner]) begin
                    nptr = (m_owner + 1) % N; np = 0;
                end
            end
            if (sel >= 0) begin
                e_sreq = 1'b1;
                e_addr = mgr_addr_i[sel*AW +: AW];
                e_we   = mgr_we_i[sel];
                e_be   = mgr_be_i[sel*4 +: 4];
                e_wd   = mgr_wdata_i[sel*DW +: DW];
            end
            cmp($sformatf("rnd%0d gnt", c),    128'(mgr_gnt_o),    128'(e_gnt));
            cmp($sformatf("rnd%0d sreq", c),   128'(sbr_req_o),    128'(e_sreq));
            cmp($sformatf("rnd%0d addr", c),   128'(sbr_addr_o),   128'(e_addr));
            cmp($sformatf("rnd%0d we", c),     128'(sbr_we_o),     128'(e_we));
            cmp($sformatf("rnd%0d be", c),     128'(sbr_be_o),     128'(e_be));
            cmp($sformatf("rnd%0d wdata", c),  128'(sbr_wdata_o),  128'(e_wd));
            cmp($sformatf("rnd%0d rvalid", c), 128'(mgr_rvalid_o), 128'(e_rv));
            cmp($sformatf("rnd%0d rdata", c),  128'(mgr_rdata_o),  128'(e_rd));
            cmp($sformatf("rnd%0d err", c),    128'(mgr_err_o),    128'(e_err));
            cmp($sformatf("rnd%0d rready", c), 128'(sbr_rready_o), 128'(e_srr));
            m_phase = np; m_owner = no; m_ptr = nptr;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
